// File: rtl/menu_pkg.sv
// Shared constants and types for the HDMI menu text overlay.
// Geometry is in character cells: 8-px wide columns, 16-px tall rows.
package menu_pkg;

  localparam int COLS    = 16;
  localparam int ROWS    = 8;
  localparam int COL_W   = $clog2(COLS);
  localparam int ROW_W   = $clog2(ROWS);
  localparam int ADDR_W  = COL_W + ROW_W;
  localparam int DEPTH   = COLS * ROWS;
  localparam int ORG_COL = 32;
  localparam int ORG_ROW = 8;

  // Clock edges after the one that samples (x,y) until color updates.
  localparam int PIPE_LAT = 3;

  localparam logic [23:0] FG     = 24'hffffff;
  localparam logic [23:0] SEL_FG = 24'hffff00;
  localparam logic [23:0] BG     = 24'h000000;
  localparam logic [7:0]  BLANK  = 8'h20;

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

  typedef enum logic {
    CLEAR = 1'b0,
    IDLE  = 1'b1
  } state_t;

endpackage

// File: rtl/menu_char_ram.sv
// Character buffer: simple dual-port RAM, one write port and one registered read port.
// A same-address read and write in one cycle returns the old contents.
module menu_char_ram
  import menu_pkg::*;
(
  input  logic              i_clk,
  input  logic              i_we,
  input  logic [ADDR_W-1:0] i_waddr,
  input  logic [7:0]        i_wdata,
  input  logic [ADDR_W-1:0] i_raddr,
  output logic [7:0]        o_rdata
);

  logic [7:0] r_mem [DEPTH];
  logic [7:0] r_rdata;

  // NOTE: the array has no reset so it maps onto block/distributed RAM; the CLEAR pass initialises it.
  always_ff @(posedge i_clk) begin
    if (i_we) r_mem[i_waddr] <= i_wdata;
    r_rdata <= r_mem[i_raddr];
  end

  assign o_rdata = r_rdata;

endmodule

// File: rtl/menu_text_layer.sv
// Menu text overlay: owns the character buffer, clears it after reset, and turns pixel
// coordinates into font-ROM addresses and then into pixel colour with row highlighting.
module menu_text_layer
  import menu_pkg::*;
(
  input  logic             clk_25mhz,
  input  logic             reset,
  input  logic             wr_en,
  input  logic [COL_W-1:0] wr_x,
  input  logic [ROW_W-1:0] wr_y,
  input  logic [7:0]       wr_ch,
  output logic             wr_ready,
  input  logic [ROW_W-1:0] sel,
  input  logic [9:0]       x,
  input  logic [9:0]       y,
  output logic [11:0]      font_addr,
  input  logic [7:0]       font_data,
  output logic [23:0]      color,
  output logic             in_window
);

  localparam logic [6:0] XC_LO = 7'(ORG_COL);
  localparam logic [6:0] XC_HI = 7'(ORG_COL + COLS);
  localparam logic [5:0] YC_LO = 6'(ORG_ROW);
  localparam logic [5:0] YC_HI = 6'(ORG_ROW + ROWS);

  state_t            r_state;
  logic [ADDR_W-1:0] r_clr_addr;
  logic              r_wr_ready;

  // NOTE: all clocked state uses non-blocking assignments so every register sees pre-edge values.
  always_ff @(posedge clk_25mhz) begin
    if (reset) begin
      r_state    <= CLEAR;
      r_clr_addr <= '0;
      r_wr_ready <= 1'b0;
    end else begin
      case (r_state)
        CLEAR: begin
          r_clr_addr <= r_clr_addr + 1'b1;
          if (r_clr_addr == LAST_ADDR) begin
            r_state    <= IDLE;
            r_wr_ready <= 1'b1;
          end
        end
        IDLE:    r_wr_ready <= 1'b1;
        default: r_state <= CLEAR;
      endcase
    end
  end

  // Writes outside the menu are dropped; only reachable with non-power-of-two geometry.
  logic              w_wr_ok;
  logic              w_we;
  logic [ADDR_W-1:0] w_waddr;
  logic [7:0]        w_wdata;

  assign w_wr_ok = wr_en && (32'(wr_x) < COLS) && (32'(wr_y) < ROWS);
  assign w_we    = !reset && ((r_state == CLEAR) || w_wr_ok);
  assign w_waddr = (r_state == CLEAR) ? r_clr_addr : {wr_y, wr_x};
  assign w_wdata = (r_state == CLEAR) ? BLANK : wr_ch;

  // S0: character cell and window test, buffer read issued.
  logic [6:0]        w_xc;
  logic [5:0]        w_yc;
  logic [6:0]        w_xoff;
  logic [5:0]        w_yoff;
  logic              w_win0;
  logic [ADDR_W-1:0] w_raddr;
  logic [7:0]        w_buf_q;

  assign w_xc    = x[9:3];
  assign w_yc    = y[9:4];
  assign w_xoff  = w_xc - XC_LO;
  assign w_yoff  = w_yc - YC_LO;
  assign w_win0  = (w_xc >= XC_LO) && (w_xc < XC_HI) && (w_yc >= YC_LO) && (w_yc < YC_HI);
  assign w_raddr = {w_yoff[ROW_W-1:0], w_xoff[COL_W-1:0]};

  menu_char_ram u_ram (
    .i_clk   (clk_25mhz),
    .i_we    (w_we),
    .i_waddr (w_waddr),
    .i_wdata (w_wdata),
    .i_raddr (w_raddr),
    .o_rdata (w_buf_q)
  );

  logic             r_win1, r_win2, r_win3;
  logic [2:0]       r_xp1, r_xp2, r_xp3;
  logic [3:0]       r_yp1;
  logic [ROW_W-1:0] r_row1, r_row2, r_row3;
  logic [11:0]      r_font_addr;
  logic [23:0]      r_color;
  logic             r_in_window;
  logic [7:0]       w_ch;
  logic             w_pix_on;

  assign w_ch     = r_win1 ? w_buf_q : BLANK;
  assign w_pix_on = font_data[3'd7 - r_xp3];

  // S1 font address, S2 waits on the font ROM, S3 colour; sel is deliberately unregistered.
  always_ff @(posedge clk_25mhz) begin
    if (reset) begin
      {r_win1, r_win2, r_win3} <= '0;
      {r_xp1, r_xp2, r_xp3}    <= '0;
      r_yp1                    <= '0;
      {r_row1, r_row2, r_row3} <= '0;
      r_font_addr              <= '0;
      r_color                  <= BG;
      r_in_window              <= 1'b0;
    end else begin
      r_win1      <= w_win0;
      r_xp1       <= x[2:0];
      r_yp1       <= y[3:0];
      r_row1      <= w_yoff[ROW_W-1:0];
      r_font_addr <= {w_ch, r_yp1};
      r_win2      <= r_win1;
      r_xp2       <= r_xp1;
      r_row2      <= r_row1;
      r_win3      <= r_win2;
      r_xp3       <= r_xp2;
      r_row3      <= r_row2;
      r_color     <= (r_win3 && w_pix_on) ? ((r_row3 == sel) ? SEL_FG : FG) : BG;
      r_in_window <= r_win3;
    end
  end

  assign wr_ready  = r_wr_ready;
  assign font_addr = r_font_addr;
  assign color     = r_color;
  assign in_window = r_in_window;

endmodule

// File: tb/tb_menu_text_layer.sv
// Bench for menu_text_layer: a pixel-level reference model (cell lookup, glyph bit, highlight)
// predicts font_addr one edge and color/in_window three edges after (x,y) is sampled.
module tb_menu_text_layer;

  logic        clk_25mhz = 1'b0;
  logic        reset;
  logic        wr_en;
  logic [3:0]  wr_x;
  logic [2:0]  wr_y;
  logic [7:0]  wr_ch;
  logic        wr_ready;
  logic [2:0]  sel;
  logic [9:0]  x, y;
  logic [11:0] font_addr;
  logic [7:0]  font_data;
  logic [23:0] color;
  logic        in_window;

  always #20 clk_25mhz = ~clk_25mhz;

  menu_text_layer dut (
    .clk_25mhz (clk_25mhz),
    .reset     (reset),
    .wr_en     (wr_en),
    .wr_x      (wr_x),
    .wr_y      (wr_y),
    .wr_ch     (wr_ch),
    .wr_ready  (wr_ready),
    .sel       (sel),
    .x         (x),
    .y         (y),
    .font_addr (font_addr),
    .font_data (font_data),
    .color     (color),
    .in_window (in_window)
  );

  // Font ROM stand-in with one cycle of read latency and random glyphs.
  logic [7:0] rom [4096];
  always @(posedge clk_25mhz) font_data <= rom[font_addr];

  int n_checks = 0;
  int n_fail   = 0;
  int e        = 0;

  logic [7:0]  mbuf     [128];
  logic [11:0] q_addr   [16];
  bit          q_win    [16];
  bit          q_bit    [16];
  bit          q_v      [16];
  int          q_row    [16];
  logic [2:0]  sel_hist [16];

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (edge %0d)", tag, act, exp, e);
    end
  endtask

  // Called at a falling edge: checks what the last rising edge produced, then records the
  // expectation for the inputs now being driven, then advances one cycle.
  task automatic tick(input bit track, input bit apply_wr);
    int i, col, row, b;
    bit win;
    logic [7:0] ch;
    logic [11:0] a;
    logic [23:0] ec;
    i = (e - 1) & 15;
    if (q_v[i]) check("font_addr", 32'(font_addr), 32'(q_addr[i]));
    i = (e - 3) & 15;
    if (q_v[i]) begin
      ec = 24'h000000;
      if (q_win[i] && q_bit[i])
        ec = (q_row[i] == int'(sel_hist[e & 15])) ? 24'hffff00 : 24'hffffff;
      check("color", 32'(color), 32'(ec));
      check("in_window", 32'(in_window), 32'(q_win[i]));
    end
    i = (e + 1) & 15;
    sel_hist[i] = sel;
    q_v[i]      = track;
    col = int'(x) / 8 - 32;
    row = int'(y) / 16 - 8;
    win = (col >= 0) && (col < 16) && (row >= 0) && (row < 8);
    ch  = win ? mbuf[row * 16 + col] : 8'h20;
    a   = {ch, y[3:0]};
    b   = 7 - int'(x[2:0]);
    q_addr[i] = a;
    q_win[i]  = win;
    q_bit[i]  = rom[a][b];
    q_row[i]  = row;
    if (apply_wr && wr_en) mbuf[int'(wr_y) * 16 + int'(wr_x)] = wr_ch;
    @(posedge clk_25mhz);
    e++;
    @(negedge clk_25mhz);
  endtask

  initial begin
    int cnt;
    for (int k = 0; k < 4096; k++) rom[k] = 8'($urandom);
    for (int k = 0; k < 128; k++) mbuf[k] = 8'h20;
    for (int k = 0; k < 16; k++) begin
      q_v[k] = 1'b0;
      sel_hist[k] = 3'd0;
    end
    reset = 1'b1; wr_en = 1'b0; wr_x = '0; wr_y = '0; wr_ch = '0;
    sel = '0; x = '0; y = '0;
    @(negedge clk_25mhz);
    tick(0, 0);
    check("rst_color", 32'(color), 32'h0);
    check("rst_in_window", 32'(in_window), 32'h0);
    check("rst_font_addr", 32'(font_addr), 32'h0);
    check("rst_wr_ready", 32'(wr_ready), 32'h0);

    // Interrupt the clear at address 60; it must start over.
    reset = 1'b0;
    repeat (60) tick(0, 0);
    check("wr_ready_mid_clear", 32'(wr_ready), 32'h0);
    reset = 1'b1;
    tick(0, 0);
    check("wr_ready_rerst", 32'(wr_ready), 32'h0);
    reset = 1'b0;

    // Count edges to wr_ready; a write at edge 50 to a cleared cell must be dropped.
    cnt = 0;
    while (!wr_ready && cnt < 300) begin
      wr_en = (cnt == 49); wr_x = 4'd5; wr_y = 3'd1; wr_ch = 8'h55;
      tick(0, 0);
      cnt++;
    end
    wr_en = 1'b0;
    check("clear_cycles", 32'(cnt), 32'd128);

    // Every cell must read as BLANK.
    for (int r = 0; r < 8; r++)
      for (int c = 0; c < 16; c++) begin
        x = 10'(256 + c * 8 + int'($urandom_range(0, 7)));
        y = 10'(128 + r * 16 + int'($urandom_range(0, 15)));
        sel = 3'($urandom);
        tick(1, 1);
      end

    // 'A' at (0,0), rendered with row 0 selected and not selected.
    wr_en = 1'b1; wr_x = 4'd0; wr_y = 3'd0; wr_ch = 8'h41; x = 10'd0; y = 10'd0;
    tick(1, 1);
    wr_en = 1'b0;
    for (int s = 0; s < 2; s++)
      for (int yy = 128; yy < 144; yy++)
        for (int xx = 256; xx < 264; xx++) begin
          sel = 3'(s); x = 10'(xx); y = 10'(yy);
          tick(1, 1);
        end

    // Just outside the window on each side.
    for (int k = 0; k < 24; k++) begin
      case (k % 4)
        0: begin x = 10'd255; y = 10'($urandom_range(128, 255)); end
        1: begin x = 10'd384; y = 10'($urandom_range(128, 255)); end
        2: begin x = 10'($urandom_range(256, 383)); y = 10'd127; end
        default: begin x = 10'($urandom_range(256, 383)); y = 10'd256; end
      endcase
      sel = 3'($urandom);
      tick(1, 1);
    end

    // Same-cycle read and write of (3,2): old char now, new char next time round.
    wr_en = 1'b1; wr_x = 4'd3; wr_y = 3'd2; wr_ch = 8'h5a;
    x = 10'(256 + 24 + 2); y = 10'(128 + 32 + 5);
    tick(1, 1);
    wr_en = 1'b0;
    repeat (3) tick(1, 1);
    tick(1, 1);

    // Random pixels around the window with random writes and selection.
    for (int k = 0; k < 2000; k++) begin
      x     = 10'($urandom_range(240, 399));
      y     = 10'($urandom_range(112, 271));
      sel   = 3'($urandom);
      wr_en = ($urandom_range(0, 3) == 0);
      wr_x  = 4'($urandom);
      wr_y  = 3'($urandom);
      wr_ch = 8'($urandom);
      tick(1, 1);
    end
    wr_en = 1'b0;
    repeat (4) tick(0, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
